// File: rtl/norm_pool_sequencer.sv
// norm_pool_sequencer: per-channel BRAM window read sequencer for the normalization/pool datapath.
// Optional stream pause input is enabled by defining NORM_SEQ_PAUSE_EN.
module norm_pool_sequencer #(
    parameter int IMAGE_SIZE_WIDTH    = 10,
    parameter int BRAM_ADDR_WIDTH     = 16,
    parameter int CHANNEL_WIDTH       = 8,
    parameter int BRAM_READ_LATENCY   = 2,
    parameter int CONST_SETTLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [IMAGE_SIZE_WIDTH-1:0] image_width,
    input  logic [IMAGE_SIZE_WIDTH-1:0] image_hight,
    input  logic [CHANNEL_WIDTH-1:0]    num_channels,
    input  logic [1:0]                  pooling_stride,
`ifdef NORM_SEQ_PAUSE_EN
    input  logic                        pause,
`endif
    input  logic                        pool_data_last_out,
    output logic                        bram_rd_en,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_rd_addr,
    output logic                        data_valid,
    output logic                        data_last,
    output logic [CHANNEL_WIDTH-1:0]    channel_idx,
    output logic                        const_load,
    output logic                        busy,
    output logic                        done,
    output logic                        cfg_error
);
    typedef enum logic [2:0] {IDLE, SETUP, LOAD_CONST, STREAM, DRAIN, DONE} state_t;
    state_t state, next;
    logic [IMAGE_SIZE_WIDTH-1:0]  w_q, h_q;
    logic [CHANNEL_WIDTH-1:0]     nch_q;
    logic                         stride2_q;
    logic [BRAM_ADDR_WIDTH-1:0]   wpc, wpc_calc, base, win;
    logic [2:0]                   settle;
    logic [BRAM_READ_LATENCY-1:0] v_pipe, l_pipe;
    logic                         hold, start_ok, last_rd, settle_end;
`ifdef NORM_SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif
    assign start_ok   = start && (pooling_stride == 2'd1 || pooling_stride == 2'd2);
    assign wpc_calc   = stride2_q ? BRAM_ADDR_WIDTH'(w_q >> 1) * BRAM_ADDR_WIDTH'(h_q >> 1)
                                  : BRAM_ADDR_WIDTH'(w_q) * BRAM_ADDR_WIDTH'(h_q);
    assign settle_end = settle == 3'(CONST_SETTLE_CYCLES - 1);
    assign last_rd    = state == STREAM && !hold && win == wpc - 1'b1;
    assign bram_rd_en   = state == STREAM && !hold;
    assign bram_rd_addr = base + win;
    assign const_load   = state == LOAD_CONST && settle == 3'd0;
    assign busy         = state == SETUP || state == LOAD_CONST || state == STREAM || state == DRAIN;
    assign done         = state == DONE;
    assign data_valid   = v_pipe[BRAM_READ_LATENCY-1];
    assign data_last    = l_pipe[BRAM_READ_LATENCY-1];
    always_comb begin
        next = state;
        case (state)
            IDLE:       next = start_ok ? SETUP : IDLE;
            SETUP:      next = (wpc_calc == '0 || nch_q == '0) ? DONE : LOAD_CONST;
            LOAD_CONST: next = settle_end ? STREAM : LOAD_CONST;
            STREAM:     next = last_rd ? DRAIN : STREAM;
            DRAIN:      next = !pool_data_last_out ? DRAIN
                             : (channel_idx == nch_q - 1'b1) ? DONE : LOAD_CONST;
            DONE:       next = IDLE;
            default:    next = IDLE;
        endcase
    end
    // the final read of a channel is tagged alongside its valid bit so data_last lines up with data_valid
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            w_q         <= '0;
            h_q         <= '0;
            nch_q       <= '0;
            stride2_q   <= 1'b0;
            wpc         <= '0;
            base        <= '0;
            win         <= '0;
            settle      <= '0;
            v_pipe      <= '0;
            l_pipe      <= '0;
            channel_idx <= '0;
            cfg_error   <= 1'b0;
        end else begin
            state  <= next;
            v_pipe <= BRAM_READ_LATENCY'({v_pipe, bram_rd_en});
            l_pipe <= BRAM_READ_LATENCY'({l_pipe, last_rd});
            settle <= state == LOAD_CONST ? settle + 1'b1 : 3'd0;
            if (state == IDLE && start)
                cfg_error <= !start_ok;
            if (state == IDLE && start_ok) begin
                w_q       <= image_width;
                h_q       <= image_hight;
                nch_q     <= num_channels;
                stride2_q <= pooling_stride == 2'd2;
            end
            if (state == SETUP) begin
                wpc         <= wpc_calc;
                base        <= '0;
                win         <= '0;
                channel_idx <= '0;
            end
            if (bram_rd_en)
                win <= last_rd ? '0 : win + 1'b1;
            // constants only advance once the pool stage reports the previous channel fully drained
            if (state == DRAIN && next == LOAD_CONST) begin
                channel_idx <= channel_idx + 1'b1;
                base        <= base + wpc;
            end
        end
    end
endmodule

// File: tb/tb_norm_pool_sequencer.sv
// tb_norm_pool_sequencer: scoreboard bench for norm_pool_sequencer; pause scenario runs when NORM_SEQ_PAUSE_EN is defined.
module tb_norm_pool_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  image_width = '0;
    logic [9:0]  image_hight = '0;
    logic [7:0]  num_channels = '0;
    logic [1:0]  pooling_stride = '0;
    logic        pool_data_last_out = 1'b0;
`ifdef NORM_SEQ_PAUSE_EN
    logic        pause = 1'b0;
`endif
    logic        bram_rd_en, data_valid, data_last, const_load, busy, done, cfg_error;
    logic [15:0] bram_rd_addr;
    logic [7:0]  channel_idx;
    int pass_cnt = 0;
    int total_cnt = 0;
    logic [15:0] addr_q[$];
    logic        last_q[$];
    logic        mon_en = 1'b0;
    logic [15:0] mon_addr;
    logic        mon_last;

    norm_pool_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .image_width(image_width), .image_hight(image_hight),
        .num_channels(num_channels), .pooling_stride(pooling_stride),
`ifdef NORM_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .pool_data_last_out(pool_data_last_out),
        .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr),
        .data_valid(data_valid), .data_last(data_last),
        .channel_idx(channel_idx), .const_load(const_load),
        .busy(busy), .done(done), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    // scoreboard: every read must match the next expected address, every valid the next expected last flag
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (bram_rd_en) begin
                total_cnt++;
                if (addr_q.size() == 0)
                    $display("FAIL rd_addr: got unexpected read at %0d, required no read", bram_rd_addr);
                else begin
                    mon_addr = addr_q.pop_front();
                    if (bram_rd_addr !== mon_addr)
                        $display("FAIL rd_addr: got %0d, required %0d", bram_rd_addr, mon_addr);
                    else pass_cnt++;
                end
            end
            if (data_valid) begin
                total_cnt++;
                if (last_q.size() == 0)
                    $display("FAIL data_valid: got unexpected valid, required none");
                else begin
                    mon_last = last_q.pop_front();
                    if (data_last !== mon_last)
                        $display("FAIL data_last: got %0b, required %0b", data_last, mon_last);
                    else pass_cnt++;
                end
            end else if (data_last) begin
                total_cnt++;
                $display("FAIL data_last: got 1 without data_valid, required 0");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int w, input int h, input int n, input int s);
        image_width = 10'(w);
        image_hight = 10'(h);
        num_channels = 8'(n);
        pooling_stride = 2'(s);
    endtask

    task automatic push_frame(input int w, input int h, input int n, input int s);
        int wpc;
        wpc = (s == 2) ? ((w / 2) * (h / 2)) % 65536 : (w * h) % 65536;
        for (int c = 0; c < n; c++)
            for (int i = 0; i < wpc; i++) begin
                addr_q.push_back(16'(c * wpc + i));
                last_q.push_back(i == wpc - 1);
            end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total_cnt++;
        if ({bram_rd_en, bram_rd_addr, data_valid, data_last, channel_idx, const_load, busy, done, cfg_error} !== '0)
            $display("FAIL reset_outputs: got rd_en=%0b addr=%0d busy=%0b done=%0b, required all 0", bram_rd_en, bram_rd_addr, busy, done);
        else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_channel();
        int cl_c = -1, first_rd = -1, last_rd_c = -1, n_rd = 0;
        int first_dv = -1, last_dv = -1, n_dl = 0, dl_c = -1, n_done = 0, done_c = -1;
        push_frame(8, 4, 1, 2);
        mon_en = 1'b1;
        set_cfg(8, 4, 1, 2);
        start = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            tick();
            start = 1'b0;
            if (const_load && cl_c < 0) cl_c = c;
            if (bram_rd_en) begin n_rd++; if (first_rd < 0) first_rd = c; last_rd_c = c; end
            if (data_valid) begin if (first_dv < 0) first_dv = c; last_dv = c; end
            if (data_last) begin n_dl++; dl_c = c; end
            if (done) begin n_done++; done_c = c; end
            pool_data_last_out = (c == 8 || c == 28);
        end
        pool_data_last_out = 1'b0;
        total_cnt++; if (cl_c !== 2) $display("FAIL const_load_cycle: got %0d, required 2", cl_c); else pass_cnt++;
        total_cnt++; if (first_rd !== 4) $display("FAIL first_read_cycle: got %0d, required 4", first_rd); else pass_cnt++;
        total_cnt++; if (last_rd_c !== 11) $display("FAIL last_read_cycle: got %0d, required 11", last_rd_c); else pass_cnt++;
        total_cnt++; if (n_rd !== 8) $display("FAIL read_count: got %0d, required 8", n_rd); else pass_cnt++;
        total_cnt++; if (first_dv !== 6) $display("FAIL first_valid_cycle: got %0d, required 6", first_dv); else pass_cnt++;
        total_cnt++; if (last_dv !== 13) $display("FAIL last_valid_cycle: got %0d, required 13", last_dv); else pass_cnt++;
        total_cnt++; if (n_dl !== 1 || dl_c !== 13) $display("FAIL data_last_cycle: got %0d pulses at %0d, required 1 at 13", n_dl, dl_c); else pass_cnt++;
        total_cnt++; if (n_done !== 1 || done_c !== 29) $display("FAIL done_cycle: got %0d pulses at %0d, required 1 at 29", n_done, done_c); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL busy_at_done: got %0b, required 0", busy); else pass_cnt++;
        tick();
        total_cnt++; if (addr_q.size() !== 0 || last_q.size() !== 0) $display("FAIL sb_empty_1: got %0d reads left, required 0", addr_q.size()); else pass_cnt++;
    endtask

    task automatic test_multi_channel();
        int loads = 0, pools = 0, bad = 0, dones = 0, sched = -1;
        push_frame(4, 4, 3, 1);
        set_cfg(4, 4, 3, 1);
        start = 1'b1;
        for (int c = 1; c < 400; c++) begin
            tick();
            start = 1'b0;
            if (const_load) begin
                total_cnt++;
                if (channel_idx !== 8'(loads)) $display("FAIL load_channel_idx: got %0d, required %0d", channel_idx, loads); else pass_cnt++;
                loads++;
            end
            if (bram_rd_en && channel_idx !== 8'(pools)) bad++;
            if (data_last) sched = c + 15;
            pool_data_last_out = (c == sched);
            if (pool_data_last_out) pools++;
            if (done) begin dones++; break; end
        end
        pool_data_last_out = 1'b0;
        total_cnt++; if (loads !== 3) $display("FAIL const_load_count: got %0d, required 3", loads); else pass_cnt++;
        total_cnt++; if (bad !== 0) $display("FAIL read_before_drain: got %0d early reads, required 0", bad); else pass_cnt++;
        total_cnt++; if (dones !== 1) $display("FAIL multi_done: got %0d, required 1", dones); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL multi_idle: got busy=%0b done=%0b, required 0 0", busy, done); else pass_cnt++;
        total_cnt++; if (addr_q.size() !== 0 || last_q.size() !== 0) $display("FAIL sb_empty_2: got %0d reads left, required 0", addr_q.size()); else pass_cnt++;
    endtask

    task automatic test_cfg_error();
        int n_rd = 0, n_done = 0;
        set_cfg(8, 4, 1, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++; if (cfg_error !== 1'b1) $display("FAIL cfg_error_set: got %0b, required 1", cfg_error); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL cfg_error_busy: got %0b, required 0", busy); else pass_cnt++;
        repeat (8) begin
            tick();
            if (bram_rd_en) n_rd++;
            if (done) n_done++;
        end
        total_cnt++; if (n_rd !== 0 || n_done !== 0) $display("FAIL cfg_error_activity: got %0d reads %0d done, required 0 0", n_rd, n_done); else pass_cnt++;
        total_cnt++; if (cfg_error !== 1'b1) $display("FAIL cfg_error_sticky: got %0b, required 1", cfg_error); else pass_cnt++;
    endtask

    task automatic test_zero_windows();
        int n_rd = 0;
        set_cfg(1, 1, 1, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (bram_rd_en) n_rd++;
        total_cnt++; if (cfg_error !== 1'b0) $display("FAIL cfg_error_clear: got %0b, required 0", cfg_error); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL zero_busy: got %0b, required 1", busy); else pass_cnt++;
        tick();
        if (bram_rd_en) n_rd++;
        total_cnt++; if (done !== 1'b1) $display("FAIL zero_done: got %0b, required 1 at cycle 2", done); else pass_cnt++;
        repeat (4) begin tick(); if (bram_rd_en) n_rd++; end
        total_cnt++; if (n_rd !== 0) $display("FAIL zero_reads: got %0d, required 0", n_rd); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int sched = -1, loads = 0, n_rd = 0, dones = 0;
        logic found = 1'b0;
        mon_en = 1'b0;
        set_cfg(4, 4, 3, 1);
        start = 1'b1;
        for (int c = 1; c < 200; c++) begin
            tick();
            start = 1'b0;
            if (bram_rd_en && channel_idx == 8'd1) begin found = 1'b1; break; end
            if (data_last) sched = c + 3;
            pool_data_last_out = (c == sched);
        end
        pool_data_last_out = 1'b0;
        total_cnt++; if (found !== 1'b1) $display("FAIL reach_channel1: got %0b, required 1", found); else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++;
        if ({bram_rd_en, bram_rd_addr, data_valid, data_last, channel_idx, const_load, busy, done, cfg_error} !== '0)
            $display("FAIL abort_outputs: got rd_en=%0b addr=%0d ch=%0d busy=%0b, required all 0", bram_rd_en, bram_rd_addr, channel_idx, busy);
        else pass_cnt++;
        reset = 1'b0;
        addr_q.delete();
        last_q.delete();
        push_frame(2, 2, 1, 1);
        mon_en = 1'b1;
        set_cfg(2, 2, 1, 1);
        start = 1'b1;
        sched = -1;
        for (int c = 1; c < 100; c++) begin
            tick();
            start = (c == 2);
            if (c == 2) set_cfg(8, 8, 5, 2);
            if (const_load) begin
                loads++;
                total_cnt++;
                if (channel_idx !== 8'd0) $display("FAIL restart_channel: got %0d, required 0", channel_idx); else pass_cnt++;
            end
            if (bram_rd_en) n_rd++;
            if (data_last) sched = c + 4;
            pool_data_last_out = (c == sched);
            if (done) begin dones++; break; end
        end
        start = 1'b0;
        pool_data_last_out = 1'b0;
        total_cnt++; if (loads !== 1) $display("FAIL restart_loads: got %0d, required 1", loads); else pass_cnt++;
        total_cnt++; if (n_rd !== 4) $display("FAIL restart_reads: got %0d, required 4", n_rd); else pass_cnt++;
        total_cnt++; if (dones !== 1) $display("FAIL restart_done: got %0d, required 1", dones); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL restart_idle: got busy=%0b, required 0", busy); else pass_cnt++;
        total_cnt++; if (addr_q.size() !== 0 || last_q.size() !== 0) $display("FAIL sb_empty_3: got %0d reads left, required 0", addr_q.size()); else pass_cnt++;
    endtask

`ifdef NORM_SEQ_PAUSE_EN
    task automatic test_pause();
        int n_rd = 0, first_rd = -1, last_rd_c = -1, n_dl = 0, sched = -1, dones = 0;
        push_frame(8, 4, 1, 2);
        set_cfg(8, 4, 1, 2);
        start = 1'b1;
        for (int c = 1; c < 100; c++) begin
            tick();
            start = 1'b0;
            pause = (c >= 7 && c <= 9);
            #1;
            if (bram_rd_en) begin n_rd++; if (first_rd < 0) first_rd = c; last_rd_c = c; end
            if (data_last) begin n_dl++; sched = c + 5; end
            pool_data_last_out = (c == sched);
            if (done) begin dones++; break; end
        end
        pause = 1'b0;
        pool_data_last_out = 1'b0;
        total_cnt++; if (n_rd !== 8) $display("FAIL pause_reads: got %0d, required 8", n_rd); else pass_cnt++;
        total_cnt++; if (last_rd_c - first_rd + 1 - n_rd !== 3) $display("FAIL pause_gap: got %0d, required 3", last_rd_c - first_rd + 1 - n_rd); else pass_cnt++;
        total_cnt++; if (last_rd_c !== 14) $display("FAIL pause_last_read: got %0d, required 14", last_rd_c); else pass_cnt++;
        total_cnt++; if (n_dl !== 1) $display("FAIL pause_data_last: got %0d, required 1", n_dl); else pass_cnt++;
        total_cnt++; if (dones !== 1) $display("FAIL pause_done: got %0d, required 1", dones); else pass_cnt++;
        tick();
        total_cnt++; if (addr_q.size() !== 0 || last_q.size() !== 0) $display("FAIL sb_empty_4: got %0d reads left, required 0", addr_q.size()); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_channel();
        test_multi_channel();
        test_cfg_error();
        test_zero_windows();
        test_back_to_back();
`ifdef NORM_SEQ_PAUSE_EN
        test_pause();
`endif
        repeat (3) tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
